cpld_serial_slave: RTL and testbench
====================================

Name: cpld_serial_slave

Overview:
- CPLD-side endpoint of the 4-wire FPGA<->CPLD serial link; the FPGA is master and drives sclk/ld/mosi.
- Deserialises 16-bit display frames into LED and 7-segment outputs, and alternates the digit select on every valid frame.
- Serialises the local switch and nav-button states back to the master on miso.
- Fully synchronous to the local clk; sclk is oversampled, never used as a clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on sclk, ld, mosi, sw_in and nav_in (minimum 2).
- FRAME_BITS, 16, data bits per frame, counted between load slots.
- DB_CYCLES, 20000, debounce stable-time in clk cycles; used only with SW_DEBOUNCE_EN.

Ports:
- clk  in  1  local clock, at least 8x sclk.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  serial clock from master.
- ld  in  1  load/frame strobe from master, high for one sclk period.
- mosi  in  1  serial data from master, LSB first.
- miso  out  1  serial data to master, LSB first.
- sw_in  in  8  raw slide switches.
- nav_in  in  5  raw nav buttons.
- led  out  8  LED drive = frame bits 7:0.
- seg  out  8  segment drive = frame bits 15:8, passed through unmodified.
- dig  out  2  one-hot digit enable.
- frame_stb  out  1  one-clk pulse when a valid frame is latched.
- frame_err  out  1  one-clk pulse when a frame is discarded.

Behaviour:
- Reset: rst is synchronous and active-high on clk. All outputs reset to 0: miso=0, led=8'h00, seg=8'h00, dig=2'b00, frame_stb=0, frame_err=0. The rx shift register, bit counter, tx shift register and synchronisers also clear.
- Reset mid-frame: any partial frame is dropped. The first valid frame after reset needs a full FRAME_BITS bit count.
- Edge detect: sclk, ld and mosi pass through SYNC_STAGES flops, plus one flop for edge detect. rise = sync high and previous low.
  - Latency from a pin edge to the internal rise pulse is SYNC_STAGES+1 clk cycles.
  - mosi and ld are sampled from the same synchronised cycle as the rise pulse.
- RX state machine: IDLE, SHIFT.
  - IDLE is entered on reset; move to SHIFT on the first rise with ld=0.
  - In SHIFT, each rise with ld=0 shifts right: rx <= {mosi, rx[15:1]}. Bit counter increments and saturates at FRAME_BITS+1.
  - rise with ld=1, bit count == FRAME_BITS: led<=rx[7:0], seg<=rx[15:8]. frame_stb pulses in the same cycle the outputs update. dig toggles: 00->01, 01->10, 10->01.
  - rise with ld=1, any other count: outputs hold, frame_err pulses, dig is unchanged.
  - Every rise with ld=1 clears the bit counter and returns the machine to SHIFT.
  - Additional ld=1 rises with no data in between count as 0 bits, so they give frame_err.
- TX path:
  - On every rise with ld=1: tx <= {3'b000, nav_s, sw_s}, where nav_s/sw_s are the conditioned inputs, then miso <= sw_s[0].
  - On each rise with ld=0: tx shifts right with zero fill, and miso <= next bit one clk after the shift.
  - miso therefore changes only just after sclk rising edges and is stable across the master's sampling edge.
  - Wire order on miso: sw[0..7], nav[0..4], 0,0,0.
  - After 16 shifts without a load slot, miso=0.
- Simultaneous events: a load and a shift never coincide, because ld is a level qualifier on the single rise pulse. Input changes during a frame do not affect tx until the next load.
- No sclk activity: all outputs hold indefinitely. There is no timeout.

Optional Feature:
- Macro: SW_DEBOUNCE_EN.
- Defined: each of the 13 synchronised sw/nav bits has its own counter. The conditioned value updates only after the raw synchronised bit differs from it for DB_CYCLES consecutive clk cycles. The counter clears whenever the raw bit matches again.
- Undefined: conditioned value = synchronised value (SYNC_STAGES flops only). No counters are synthesised and DB_CYCLES is unused.

Test Plan:
- Reset then idle sclk: miso, led, seg, dig, frame_stb and frame_err all 0 for 1000 clk.
- Frame 16'hA55A (LSB first), then ld slot: led=8'h5A, seg=8'hA5, dig=2'b01, frame_stb exactly one clk. Second frame 16'h0F3C: led=8'h3C, seg=8'h0F, dig=2'b10.
- sw_in=8'hC3, nav_in=5'b10110 held, then ld slot and 16 shifts: bench captures miso at sclk falling edges as 0xC3 then 0b10110 then 000 (word 16'h16C3).
- 12 bits then ld slot: frame_err pulse, led/seg/dig unchanged. The next full 16-bit frame 16'h1234 latches normally.
- rst asserted after 9 bits of frame 16'hFFFF: all outputs 0. The following complete frame 16'h00FF gives led=8'hFF, seg=8'h00, dig=2'b01.
- SW_DEBOUNCE_EN, DB_CYCLES=100: sw_in[0] glitch of 50 clk gives no change in the tx word. A level held 150 clk appears as bit 0=1 at the next ld slot.

Source files
------------

// File: rtl/cpld_serial_slave.sv
// CPLD-side endpoint of the FPGA<->CPLD 4-wire serial link (FPGA is master).
// Latency: pin edge -> internal rise pulse SYNC_STAGES+1 clk; frame outputs / miso update one clk after that.
// Backpressure: none; the master paces everything through sclk, and outputs hold when sclk is idle.
//
// Ports:
//   clk, rst            local clock (>= 8x sclk), synchronous active-high reset
//   sclk, ld, mosi      master serial clock, load-slot strobe, data in (LSB first)
//   miso                data to master (LSB first): sw[0..7], nav[0..4], 0,0,0
//   sw_in, nav_in       raw slide switches / nav buttons
//   led, seg            frame bits 7:0 / 15:8
//   dig                 one-hot digit enable, alternates on every valid frame
//   frame_stb/frame_err one-clk pulse on frame latched / frame discarded
//
// Optional build macro SW_DEBOUNCE_EN: adds a DB_CYCLES stable-time debouncer per sw/nav bit.

module cpld_serial_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int DB_CYCLES   = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ld,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] sw_in,
    input  logic [4:0] nav_in,
    output logic [7:0] led,
    output logic [7:0] seg,
    output logic [1:0] dig,
    output logic       frame_stb,
    output logic       frame_err
);

    // Elaboration-time parameter sanity check.
    generate
        if (SYNC_STAGES < 2 || FRAME_BITS < 1 || DB_CYCLES < 1) begin : g_param_check
            $error("cpld_serial_slave: SYNC_STAGES must be >= 2, FRAME_BITS and DB_CYCLES >= 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ld_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [7:0]             r_sw_sync  [SYNC_STAGES];
    logic [4:0]             r_nav_sync [SYNC_STAGES];
    logic                   r_sclk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ld_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= '0;
                r_nav_sync[i] <= '0;
            end
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ld_sync   <= {r_ld_sync[SYNC_STAGES-2:0],   ld};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_sw_sync[0]  <= sw_in;
            r_nav_sync[0] <= nav_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= r_sw_sync[i-1];
                r_nav_sync[i] <= r_nav_sync[i-1];
            end
        end
    end

    logic w_rise;
    logic w_ld_s;
    logic w_mosi_s;

    // ld and mosi are taken from the same synchronised cycle as the rise pulse,
    // so they carry the level the master set up before its sclk rising edge.
    assign w_rise   = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_ld_s   = r_ld_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Switch / nav conditioning
    // ------------------------------------------------------------------
    logic [12:0] w_in_raw;
    logic [12:0] w_in_cond;

    assign w_in_raw = {r_nav_sync[SYNC_STAGES-1], r_sw_sync[SYNC_STAGES-1]};

`ifdef SW_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [12:0]     r_db_val;
    logic [DB_W-1:0] r_db_cnt [13];

    // A bit's conditioned value follows the raw value only after it has
    // disagreed for DB_CYCLES consecutive cycles; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_val <= '0;
            for (int i = 0; i < 13; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (w_in_raw[i] == r_db_val[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    r_db_val[i] <= w_in_raw[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_in_cond = r_db_val;
`else
    assign w_in_cond = w_in_raw;
`endif

    // ------------------------------------------------------------------
    // RX state machine
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_do_shift;
    logic             w_do_latch;
    logic             w_do_err;
    logic [CNT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load slot is ld=1 qualified on the single rise pulse, so a shift and
    // a load can never happen on the same rise. The first data bit after
    // reset is counted, so a frame straight out of reset is complete.
    always_comb begin
        w_state_nxt = r_state;
        w_do_shift  = 1'b0;
        w_do_latch  = 1'b0;
        w_do_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_SHIFT;
                    if (w_ld_s) begin
                        w_do_err = 1'b1;
                    end else begin
                        w_do_shift = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_state_nxt = ST_SHIFT;
                    if (w_ld_s) begin
                        if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
                            w_do_latch = 1'b1;
                        end else begin
                            w_do_err = 1'b1;
                        end
                    end else begin
                        w_do_shift = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX datapath and display outputs
    // ------------------------------------------------------------------
    logic [15:0] r_rx;
    logic [7:0]  r_led;
    logic [7:0]  r_seg;
    logic [1:0]  r_dig;
    logic        r_frame_stb;
    logic        r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx        <= '0;
            r_bit_cnt   <= '0;
            r_led       <= '0;
            r_seg       <= '0;
            r_dig       <= '0;
            r_frame_stb <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_stb <= w_do_latch;
            r_frame_err <= w_do_err;
            if (w_do_shift) begin
                r_rx <= {w_mosi_s, r_rx[15:1]};
                // Saturating one past a full frame keeps over-long frames invalid.
                if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_do_latch || w_do_err) begin
                r_bit_cnt <= '0;
            end
            if (w_do_latch) begin
                r_led <= r_rx[7:0];
                r_seg <= r_rx[15:8];
                // 00 (post-reset) and any illegal code restart at digit 0.
                r_dig <= (r_dig == 2'b01) ? 2'b10 : 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [15:0] r_tx;
    logic        r_tx_adv;
    logic        r_miso;

    // miso follows the tx register one clk after each shift, so it changes
    // only just after an sclk rising edge and is stable at the master's
    // falling-edge sample point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx     <= '0;
            r_tx_adv <= 1'b0;
            r_miso   <= 1'b0;
        end else begin
            r_tx_adv <= w_do_shift;
            if (r_tx_adv) begin
                r_miso <= r_tx[0];
            end
            if (w_do_shift) begin
                r_tx <= {1'b0, r_tx[15:1]};
            end
            if (w_do_latch || w_do_err) begin
                r_tx   <= {3'b000, w_in_cond};
                r_miso <= w_in_cond[0];
            end
        end
    end

    assign miso      = r_miso;
    assign led       = r_led;
    assign seg       = r_seg;
    assign dig       = r_dig;
    assign frame_stb = r_frame_stb;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_cpld_serial_slave.sv
// Directed bench for cpld_serial_slave: drives sclk/ld/mosi as the master,
// captures miso on sclk falling edges, and checks display outputs and pulses.
module tb_cpld_serial_slave;

    localparam int SCLK_HALF = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ld;
    logic       mosi;
    logic       miso;
    logic [7:0] sw_in;
    logic [4:0] nav_in;
    logic [7:0] led;
    logic [7:0] seg;
    logic [1:0] dig;
    logic       frame_stb;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int exp_stb = 0;
    int exp_err = 0;

    logic        cap_bits [16];
    logic        cap_ld;
    logic [15:0] tx_word;
    logic        any_nz;

    cpld_serial_slave #(
        .SYNC_STAGES(2),
        .FRAME_BITS (16),
        .DB_CYCLES  (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ld       (ld),
        .mosi     (mosi),
        .miso     (miso),
        .sw_in    (sw_in),
        .nav_in   (nav_in),
        .led      (led),
        .seg      (seg),
        .dig      (dig),
        .frame_stb(frame_stb),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && frame_stb) stb_cnt++;
        if (!rst && frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sclk period; miso is captured at the falling edge that ends it.
    task automatic send_bit(input logic b, input logic l, output logic c);
        mosi = b;
        ld   = l;
        sclk = 1'b0;
        #SCLK_HALF;
        sclk = 1'b1;
        #SCLK_HALF;
        sclk = 1'b0;
        c = miso;
    endtask

    task automatic send_bits(input logic [15:0] d, input int n);
        logic c;
        for (int i = 0; i < n; i++) begin
            send_bit(d[i], 1'b0, c);
            cap_bits[i] = c;
        end
    endtask

    task automatic send_ld();
        logic c;
        send_bit(1'b0, 1'b1, c);
        cap_ld = c;
        ld = 1'b0;
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] e_led,
                            input logic [7:0] e_seg, input logic [1:0] e_dig);
        chk({tag, "_led"}, led, e_led);
        chk({tag, "_seg"}, seg, e_seg);
        chk({tag, "_dig"}, dig, e_dig);
    endtask

    initial begin
        rst    = 1'b1;
        sclk   = 1'b0;
        ld     = 1'b0;
        mosi   = 1'b0;
        sw_in  = 8'h00;
        nav_in = 5'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle sclk.
        chk("rst_miso", miso, 0);
        chk_disp("rst", 8'h00, 8'h00, 2'b00);
        any_nz = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (miso || frame_stb || frame_err || led != 0 || seg != 0 || dig != 0)
                any_nz = 1'b1;
        end
        chk("idle_outputs_zero", any_nz, 0);

        // Two valid frames.
        send_bits(16'hA55A, 16);
        send_ld();
        exp_stb++;
        chk_disp("f1", 8'h5A, 8'hA5, 2'b01);
        chk("f1_stb_cnt", stb_cnt, exp_stb);
        chk("f1_err_cnt", err_cnt, exp_err);

        send_bits(16'h0F3C, 16);
        send_ld();
        exp_stb++;
        chk_disp("f2", 8'h3C, 8'h0F, 2'b10);
        chk("f2_stb_cnt", stb_cnt, exp_stb);

        // TX word: load slot with no data since the last load is a 0-bit frame.
        sw_in  = 8'hC3;
        nav_in = 5'b10110;
        repeat (200) @(negedge clk);
        send_ld();
        exp_err++;
        chk("tx_ld_err_cnt", err_cnt, exp_err);
        chk_disp("tx_ld_hold", 8'h3C, 8'h0F, 2'b10);
        send_bits(16'hBEEF, 16);
        tx_word[0] = cap_ld;
        for (int k = 1; k < 16; k++) tx_word[k] = cap_bits[k-1];
        chk("tx_word", tx_word, 16'h16C3);
        chk("tx_after16", cap_bits[15], 0);
        send_ld();
        exp_stb++;
        chk_disp("f3", 8'hEF, 8'hBE, 2'b01);
        chk("f3_stb_cnt", stb_cnt, exp_stb);

        // Short frame is discarded, next full frame latches.
        send_bits(16'h0ABC, 12);
        send_ld();
        exp_err++;
        chk("short_err_cnt", err_cnt, exp_err);
        chk("short_stb_cnt", stb_cnt, exp_stb);
        chk_disp("short_hold", 8'hEF, 8'hBE, 2'b01);
        send_bits(16'h1234, 16);
        send_ld();
        exp_stb++;
        chk_disp("f4", 8'h34, 8'h12, 2'b10);
        chk("f4_err_cnt", err_cnt, exp_err);

        // Reset mid-frame.
        send_bits(16'hFFFF, 9);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_disp("midrst", 8'h00, 8'h00, 2'b00);
        chk("midrst_miso", miso, 0);
        chk("midrst_stb", frame_stb, 0);
        chk("midrst_err", frame_err, 0);
        send_bits(16'h00FF, 16);
        send_ld();
        exp_stb++;
        chk_disp("f5", 8'hFF, 8'h00, 2'b01);
        chk("f5_stb_cnt", stb_cnt, exp_stb);
        chk("f5_err_cnt", err_cnt, exp_err);

`ifdef SW_DEBOUNCE_EN
        // Debounce: a 50-clk glitch is rejected, a 150-clk level is accepted.
        sw_in  = 8'h00;
        nav_in = 5'h00;
        repeat (200) @(negedge clk);
        sw_in[0] = 1'b1;
        repeat (50) @(negedge clk);
        sw_in[0] = 1'b0;
        repeat (20) @(negedge clk);
        send_ld();
        chk("db_glitch_bit0", cap_ld, 0);
        sw_in[0] = 1'b1;
        repeat (150) @(negedge clk);
        send_ld();
        chk("db_hold_bit0", cap_ld, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
